// File: rtl/mod_6_counter.sv
// ---------------------------------------------------------------------------
// mod_6_counter
//
// Purpose:
//   This is a free-running modulo-MODULUS up-counter. At the defaults it is a
//   divide-by-6 sequencer that counts 0,1,2,3,4,5 and then wraps back to 0.
//   The counter has no enable or load input, so it advances on every rising
//   clock edge while out of reset. If the count register ever holds a value
//   of MODULUS or more, the next edge returns it to 0, so the counter cannot
//   lock up.
//
// Parameters:
//   MODULUS - number of states in the count sequence (2 .. 2**WIDTH)
//   WIDTH   - bit width of q (2**WIDTH >= MODULUS)
//
// Ports:
//   clk   in   1      system clock, rising-edge active
//   rst_n in   1      asynchronous active-low reset, clears q to 0
//   q     out  WIDTH  current count, driven straight from the count flop
//   tc    out  1      terminal count, high while q == MODULUS-1
// ---------------------------------------------------------------------------
module mod_6_counter #(
  parameter int MODULUS = 6,
  parameter int WIDTH   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [WIDTH-1:0] q,
  output logic             tc
);

  // Reject parameter combinations that cannot hold the requested sequence.
  if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_params
    $error("mod_6_counter: MODULUS (%0d) must be in 2..2**WIDTH (WIDTH=%0d)",
           MODULUS, WIDTH);
  end

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Next count. The wrap uses >= rather than == so that an out-of-range
  // value (for example after an upset) also returns to 0 on the next edge.
  always_comb begin
    cnt_d = cnt_q + WIDTH'(1);
    if (cnt_q >= LAST) begin
      cnt_d = '0;
    end
  end

  // Count register. The reset is asynchronous and takes effect without
  // waiting for a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q  = cnt_q;
  assign tc = (cnt_q == LAST);

endmodule

// File: tb/tb_mod_6_counter.sv
// ---------------------------------------------------------------------------
// tb_mod_6_counter
//
// This testbench drives mod_6_counter through several phases: power-up reset,
// release and counting, a long free run, an asynchronous reset in mid-count,
// a reset while tc is high, and recovery from the illegal states 6 and 7.
// On each rising edge, a reference model pushes the expected count into a
// queue. The bench then pops that value and compares it with the design
// outputs 1 time unit after the edge.
// ---------------------------------------------------------------------------
module tb_mod_6_counter;

  localparam int MOD = 6;
  localparam int W   = 3;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] q;
  logic         tc;

  int checks   = 0;
  int failures = 0;
  int modelQ   = 0;
  int edgeNum  = 0;
  int expQ[$];

  mod_6_counter #(.MODULUS(MOD), .WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .q    (q),
    .tc   (tc)
  );

  // The clock has a period of 10, with rising edges at 5, 15, 25 and so on.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // This watchdog guarantees that the run terminates even if the bench stalls.
  initial begin
    #50000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts every check and reports each mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s at t=%0t: actual=%0d required=%0d",
               tag, $time, actual, expected);
    end
  endtask

  // Wait for one rising edge, push the model's expected count, then pop it
  // and compare it with q and tc shortly after the edge.
  task automatic applyStimulus();
    int expVal;
    @(posedge clk);
    edgeNum++;
    if (!rst_n)                modelQ = 0;
    else if (modelQ >= MOD-1)  modelQ = 0;
    else                       modelQ = modelQ + 1;
    expQ.push_back(modelQ);
    #1;
    expVal = expQ.pop_front();
    checkOutput("q", 32'(q), 32'(expVal));
    checkOutput("tc", 32'(tc), 32'(expVal == MOD-1));
  endtask

  initial begin
    int relSeq[7];
    int tcCount;
    int lastTcEdge;
    int guard;
    relSeq = '{1, 2, 3, 4, 5, 0, 1};

    // Power-up reset: q and tc must stay 0 across the edges at 5 and 15.
    rst_n = 1'b0;
    #1;
    checkOutput("resetQ", 32'(q), 32'd0);
    checkOutput("resetTc", 32'(tc), 32'd0);
    applyStimulus();
    applyStimulus();
    #4;
    rst_n = 1'b1;
    #1;
    checkOutput("releaseNoStep", 32'(q), 32'd0);

    // Release and long run: 20 edges, from t=25 to t=215.
    tcCount    = 0;
    lastTcEdge = -1;
    for (int i = 0; i < 20; i++) begin
      applyStimulus();
      if (i < 7) checkOutput("releaseSeq", 32'(q), 32'(relSeq[i]));
      checkOutput("qLegal", 32'(q < W'(MOD)), 32'd1);
      if (tc) begin
        if (lastTcEdge >= 0)
          checkOutput("tcSpacing", 32'(edgeNum - lastTcEdge), 32'd6);
        lastTcEdge = edgeNum;
        tcCount++;
      end
    end
    checkOutput("tcPulses", 32'(tcCount), 32'd3);

    // Asynchronous reset in mid-count, asserted between edges at t=220.
    #4;
    rst_n  = 1'b0;
    modelQ = 0;
    #1;
    checkOutput("asyncQ", 32'(q), 32'd0);
    checkOutput("asyncTc", 32'(tc), 32'd0);
    applyStimulus();
    #4;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) applyStimulus();

    // Assert reset while tc is high.
    guard = 0;
    while (modelQ != MOD-1 && guard < MOD) begin
      applyStimulus();
      guard++;
    end
    checkOutput("reachTc", 32'(tc), 32'd1);
    #3;
    rst_n  = 1'b0;
    modelQ = 0;
    #1;
    checkOutput("tcResetQ", 32'(q), 32'd0);
    checkOutput("tcResetTc", 32'(tc), 32'd0);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 7; i++) applyStimulus();

    // Recovery from the illegal states 6 and 7.
    for (int v = 6; v <= 7; v++) begin
      @(negedge clk);
      force dut.cnt_q = W'(v);
      #1;
      checkOutput("forcedQ", 32'(q), 32'(v));
      checkOutput("forcedTc", 32'(tc), 32'd0);
      release dut.cnt_q;
      modelQ = v;
      applyStimulus();
      for (int i = 0; i < 3; i++) applyStimulus();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
